// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// the substitute read word returned for out-of-range addresses, and the
// wait-state counter width.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP,
        HOLD
    } state_t;

    localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;
    localparam int          WAIT_CNT_W    = 4;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM with one-cycle registered read.
// The read port samples the address on every edge; a write and a read to the
// same address in one cycle return the old word. Contents have no reset.
// INIT_FILE is carried for the preload image used by the enclosing system.
module ram_sp_sync
    import mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write on we, and register the addressed word for the read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the core bus.
// Accepts a Read / write_mem level request, inserts WAIT_STATES wait cycles,
// performs one RAM access and raises mem_ready for a single cycle. A request
// level still high after completion parks the FSM in HOLD until it drops, so a
// held level never triggers a second access.
// Optional feature: define MEM_ADDR_CHECK_EN to flag MAR values with non-zero
// bits above ADDR_W (no RAM write, BAD_ADDR_DATA on read, err pulse).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Read,
    input  logic              write_mem,
    input  logic [31:0]       MAR,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_wait_states_range
        $error("mem_responder: WAIT_STATES must be within 0..15");
    end

    state_t                  state_q;
    state_t                  state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    op_write_q;
    logic                    bad_q;
    logic                    req;
    logic                    addr_bad;
    logic                    ram_we;
    logic [DATA_W-1:0]       ram_rdata;

    assign req = Read | write_mem;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = |MAR[31:ADDR_W];
`else
    logic unused_mar_hi;
    assign unused_mar_hi = ^MAR[31:ADDR_W];
    assign addr_bad      = 1'b0;
`endif

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs decoded from the current state
    always_comb begin
        state_d   = state_q;
        mem_ready = 1'b0;
        busy      = (state_q != IDLE);
        ram_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_we  = op_write_q & ~bad_q;
                state_d = RESP;
            end
            RESP: begin
                mem_ready = 1'b1;
                state_d   = req ? HOLD : IDLE;
            end
            HOLD: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MEM_ADDR_CHECK_EN
    assign err = mem_ready & bad_q;
`else
    assign err = 1'b0;
`endif

    // Wait-state counter: loaded when a request is accepted, counts down in WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == IDLE && req) begin
            cnt_q <= WAIT_CNT_W'(WAIT_STATES);
        end else if (state_q == WAIT && cnt_q != '0) begin
            cnt_q <= cnt_q - WAIT_CNT_W'(1);
        end
    end

    // Capture the request so later changes on the bus cannot disturb the access;
    // write_mem wins when both request lines are high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            bad_q      <= 1'b0;
        end else if (state_q == IDLE && req) begin
            addr_q     <= MAR[ADDR_W-1:0];
            wdata_q    <= data_in;
            op_write_q <= write_mem;
            bad_q      <= addr_bad;
        end
    end

    // Read data register: the RAM has been reading the latched address since
    // the cycle after capture, so its word is settled by the end of ACCESS and
    // lands in data_out exactly as mem_ready rises; writes leave it untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (state_q == ACCESS && !op_write_q) begin
            data_out <= bad_q ? DATA_W'(BAD_ADDR_DATA) : ram_rdata;
        end
    end

    ram_sp_sync #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule
